// File: rtl/complete_stage_pkg.sv
// Shared types and constants for the complete/retire stage: ROB row layout,
// pipeline widths and the store opcode that decides whether a retire frees a register.
package complete_stage_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = 4;
  localparam int PREG_W    = 6;
  localparam int DATA_W    = 32;
  localparam int OPC_W     = 7;
  localparam int FU_W      = 2;
  localparam int NUM_BUS   = 3;

  localparam logic [OPC_W-1:0] OPC_STORE = 7'b0100011;

  typedef struct packed {
    logic              v;
    logic              is_store;
    logic [PREG_W-1:0] phy_reg;
    logic [PREG_W-1:0] old_phy;
    logic [DATA_W-1:0] result;
    logic              comp;
  } rob_row;

  function automatic rob_row new_row(input logic [PREG_W-1:0] preg,
                                     input logic [OPC_W-1:0]  opc,
                                     input logic [PREG_W-1:0] old);
    rob_row r;
    r          = '0;
    r.v        = 1'b1;
    r.is_store = (opc == OPC_STORE);
    r.phy_reg  = preg;
    r.old_phy  = old;
    return r;
  endfunction

endpackage

// File: rtl/complete_stage.sv
// Complete/retire stage: 16-entry ROB with 2-wide allocation, 3 result buses,
// 1-cycle result forwarding and in-order retirement of up to 2 entries per cycle.
module complete_stage
  import complete_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_flag_ci,
  input  logic [DATA_W-1:0]    result_c1,
  input  logic [DATA_W-1:0]    result_c2,
  input  logic [DATA_W-1:0]    result_c3,
  input  logic [PREG_W-1:0]    result_dest_c1,
  input  logic [PREG_W-1:0]    result_dest_c2,
  input  logic [PREG_W-1:0]    result_dest_c3,
  input  logic                 result_valid_c1,
  input  logic                 result_valid_c2,
  input  logic                 result_valid_c3,
  input  logic [ROB_IDX_W-1:0] result_ROB_c1,
  input  logic [ROB_IDX_W-1:0] result_ROB_c2,
  input  logic [ROB_IDX_W-1:0] result_ROB_c3,
  input  logic [FU_W-1:0]      result_FU_c1,
  input  logic [FU_W-1:0]      result_FU_c2,
  input  logic [FU_W-1:0]      result_FU_c3,
  input  logic                 rob_valid_1,
  input  logic                 rob_valid_2,
  input  logic [PREG_W-1:0]    rob_p_reg_1,
  input  logic [PREG_W-1:0]    rob_p_reg_2,
  input  logic [OPC_W-1:0]     rob_opcode_1,
  input  logic [OPC_W-1:0]     rob_opcode_2,
  input  logic [PREG_W-1:0]    o_rob_p_reg_1,
  input  logic [PREG_W-1:0]    o_rob_p_reg_2,
  output logic [ROB_IDX_W-1:0] rob_tail,
  output logic                 rob_full,
  output logic                 en_flag_co,
  output logic                 forward_flag_1,
  output logic                 forward_flag_2,
  output logic                 forward_flag_3,
  output logic [PREG_W-1:0]    dest_R_1,
  output logic [PREG_W-1:0]    dest_R_2,
  output logic [PREG_W-1:0]    dest_R_3,
  output logic [DATA_W-1:0]    forwarded_data_1,
  output logic [DATA_W-1:0]    forwarded_data_2,
  output logic [DATA_W-1:0]    forwarded_data_3,
  output logic                 retire_flag_1,
  output logic                 retire_flag_2,
  output logic [PREG_W-1:0]    fp_ind_1,
  output logic [PREG_W-1:0]    fp_ind_2
);

  rob_row               rob      [ROB_DEPTH];
  rob_row               rob_next [ROB_DEPTH];
  logic [ROB_IDX_W-1:0] head, tail, head_plus1, slot2;
  logic [ROB_IDX_W-1:0] head_next, tail_next;
  logic [ROB_IDX_W:0]   count, count_next;
  logic                 full, alloc1, alloc2, ret1, ret2;
  logic [1:0]           n_alloc, n_ret;

  logic                 bus_valid [NUM_BUS];
  logic [DATA_W-1:0]    bus_data  [NUM_BUS];
  logic [PREG_W-1:0]    bus_dest  [NUM_BUS];
  logic [ROB_IDX_W-1:0] bus_rob   [NUM_BUS];
  logic [NUM_BUS-1:0]   fire;

  logic [NUM_BUS-1:0]   fwd_flag;
  logic [PREG_W-1:0]    fwd_dest [NUM_BUS];
  logic [DATA_W-1:0]    fwd_data [NUM_BUS];
  logic                 unused_fields;

  assign bus_valid[0] = result_valid_c1;
  assign bus_valid[1] = result_valid_c2;
  assign bus_valid[2] = result_valid_c3;
  assign bus_data[0]  = result_c1;
  assign bus_data[1]  = result_c2;
  assign bus_data[2]  = result_c3;
  assign bus_dest[0]  = result_dest_c1;
  assign bus_dest[1]  = result_dest_c2;
  assign bus_dest[2]  = result_dest_c3;
  assign bus_rob[0]   = result_ROB_c1;
  assign bus_rob[1]   = result_ROB_c2;
  assign bus_rob[2]   = result_ROB_c3;

  assign head_plus1 = head + ROB_IDX_W'(1);
  assign rob_tail   = tail;
  assign rob_full   = full;

  // Next ROB image: allocation lands only on free entries and completion only on
  // valid ones, so the later bus overwriting an earlier one is the only real overlap.
  always_comb begin
    full    = (count > (ROB_IDX_W+1)'(ROB_DEPTH - 2));
    alloc1  = rob_valid_1 && !full;
    alloc2  = rob_valid_2 && !full;
    slot2   = rob_valid_1 ? tail + ROB_IDX_W'(1) : tail;
    n_alloc = {1'b0, alloc1} + {1'b0, alloc2};
    ret1    = rob[head].v && rob[head].comp;
    ret2    = ret1 && rob[head_plus1].v && rob[head_plus1].comp;
    n_ret   = {1'b0, ret1} + {1'b0, ret2};
    fire    = '0;
    rob_next = rob;
    if (alloc1) rob_next[tail]  = new_row(rob_p_reg_1, rob_opcode_1, o_rob_p_reg_1);
    if (alloc2) rob_next[slot2] = new_row(rob_p_reg_2, rob_opcode_2, o_rob_p_reg_2);
    for (int k = 0; k < NUM_BUS; k++) begin
      fire[k] = en_flag_ci && bus_valid[k];
      if (fire[k] && rob[bus_rob[k]].v) begin
        rob_next[bus_rob[k]].result = bus_data[k];
        rob_next[bus_rob[k]].comp   = 1'b1;
      end
    end
    if (ret1) rob_next[head].v       = 1'b0;
    if (ret2) rob_next[head_plus1].v = 1'b0;
    head_next  = head + ROB_IDX_W'(n_ret);
    tail_next  = tail + ROB_IDX_W'(n_alloc);
    count_next = count + (ROB_IDX_W+1)'(n_alloc) - (ROB_IDX_W+1)'(n_ret);
  end

  // Stored results and FU ids are architectural bookkeeping that nothing here consumes.
  always_comb begin
    unused_fields = ^{result_FU_c1, result_FU_c2, result_FU_c3};
    for (int i = 0; i < ROB_DEPTH; i++)
      unused_fields = unused_fields ^ (^{rob[i].phy_reg, rob[i].result});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      en_flag_co    <= 1'b0;
      fwd_flag      <= '0;
      for (int k = 0; k < NUM_BUS; k++) begin
        fwd_dest[k] <= '0;
        fwd_data[k] <= '0;
      end
      retire_flag_1 <= 1'b0;
      retire_flag_2 <= 1'b0;
      fp_ind_1      <= '0;
      fp_ind_2      <= '0;
    end else begin
      rob           <= rob_next;
      head          <= head_next;
      tail          <= tail_next;
      count         <= count_next;
      en_flag_co    <= en_flag_ci;
      fwd_flag      <= fire;
      for (int k = 0; k < NUM_BUS; k++) begin
        fwd_dest[k] <= fire[k] ? bus_dest[k] : '0;
        fwd_data[k] <= fire[k] ? bus_data[k] : '0;
      end
      retire_flag_1 <= ret1 && !rob[head].is_store;
      retire_flag_2 <= ret2 && !rob[head_plus1].is_store;
      fp_ind_1      <= (ret1 && !rob[head].is_store)       ? rob[head].old_phy       : '0;
      fp_ind_2      <= (ret2 && !rob[head_plus1].is_store) ? rob[head_plus1].old_phy : '0;
    end
  end

  assign forward_flag_1   = fwd_flag[0];
  assign forward_flag_2   = fwd_flag[1];
  assign forward_flag_3   = fwd_flag[2];
  assign dest_R_1         = fwd_dest[0];
  assign dest_R_2         = fwd_dest[1];
  assign dest_R_3         = fwd_dest[2];
  assign forwarded_data_1 = fwd_data[0];
  assign forwarded_data_2 = fwd_data[1];
  assign forwarded_data_3 = fwd_data[2];

endmodule

// File: tb/tb_complete_stage.sv
// Self-checking bench for complete_stage: forwarding and freed-register scoreboards
// plus directed checks of retire timing, full/drop behaviour, stores and wrap-around.
module tb_complete_stage;
  import complete_stage_pkg::*;

  localparam logic [6:0] OPC_ADD = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_flag_ci;
  logic [31:0] result_c1, result_c2, result_c3;
  logic [5:0]  result_dest_c1, result_dest_c2, result_dest_c3;
  logic        result_valid_c1, result_valid_c2, result_valid_c3;
  logic [3:0]  result_ROB_c1, result_ROB_c2, result_ROB_c3;
  logic [1:0]  result_FU_c1, result_FU_c2, result_FU_c3;
  logic        rob_valid_1, rob_valid_2;
  logic [5:0]  rob_p_reg_1, rob_p_reg_2;
  logic [6:0]  rob_opcode_1, rob_opcode_2;
  logic [5:0]  o_rob_p_reg_1, o_rob_p_reg_2;
  logic [3:0]  rob_tail;
  logic        rob_full, en_flag_co;
  logic        forward_flag_1, forward_flag_2, forward_flag_3;
  logic [5:0]  dest_R_1, dest_R_2, dest_R_3;
  logic [31:0] forwarded_data_1, forwarded_data_2, forwarded_data_3;
  logic        retire_flag_1, retire_flag_2;
  logic [5:0]  fp_ind_1, fp_ind_2;

  typedef struct packed {
    logic [2:0]  flag;
    logic [5:0]  d1, d2, d3;
    logic [31:0] x1, x2, x3;
  } fwd_t;

  fwd_t       fwdQ[$];
  logic [5:0] freeQ[$];
  int         testCount = 0;
  int         failCount = 0;
  int         tailExp = 0;
  int         pendingAlloc = 0;

  complete_stage dut (
    .clk(clk), .rst(rst), .en_flag_ci(en_flag_ci),
    .result_c1(result_c1), .result_c2(result_c2), .result_c3(result_c3),
    .result_dest_c1(result_dest_c1), .result_dest_c2(result_dest_c2), .result_dest_c3(result_dest_c3),
    .result_valid_c1(result_valid_c1), .result_valid_c2(result_valid_c2), .result_valid_c3(result_valid_c3),
    .result_ROB_c1(result_ROB_c1), .result_ROB_c2(result_ROB_c2), .result_ROB_c3(result_ROB_c3),
    .result_FU_c1(result_FU_c1), .result_FU_c2(result_FU_c2), .result_FU_c3(result_FU_c3),
    .rob_valid_1(rob_valid_1), .rob_valid_2(rob_valid_2),
    .rob_p_reg_1(rob_p_reg_1), .rob_p_reg_2(rob_p_reg_2),
    .rob_opcode_1(rob_opcode_1), .rob_opcode_2(rob_opcode_2),
    .o_rob_p_reg_1(o_rob_p_reg_1), .o_rob_p_reg_2(o_rob_p_reg_2),
    .rob_tail(rob_tail), .rob_full(rob_full), .en_flag_co(en_flag_co),
    .forward_flag_1(forward_flag_1), .forward_flag_2(forward_flag_2), .forward_flag_3(forward_flag_3),
    .dest_R_1(dest_R_1), .dest_R_2(dest_R_2), .dest_R_3(dest_R_3),
    .forwarded_data_1(forwarded_data_1), .forwarded_data_2(forwarded_data_2),
    .forwarded_data_3(forwarded_data_3),
    .retire_flag_1(retire_flag_1), .retire_flag_2(retire_flag_2),
    .fp_ind_1(fp_ind_1), .fp_ind_2(fp_ind_2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    rst = 1'b0; en_flag_ci = 1'b0;
    result_c1 = '0; result_c2 = '0; result_c3 = '0;
    result_dest_c1 = '0; result_dest_c2 = '0; result_dest_c3 = '0;
    result_valid_c1 = 1'b0; result_valid_c2 = 1'b0; result_valid_c3 = 1'b0;
    result_ROB_c1 = '0; result_ROB_c2 = '0; result_ROB_c3 = '0;
    result_FU_c1 = 2'd0; result_FU_c2 = 2'd1; result_FU_c3 = 2'd2;
    rob_valid_1 = 1'b0; rob_valid_2 = 1'b0;
    rob_p_reg_1 = '0; rob_p_reg_2 = '0;
    rob_opcode_1 = '0; rob_opcode_2 = '0;
    o_rob_p_reg_1 = '0; o_rob_p_reg_2 = '0;
  endtask

  // Accepted allocations only: non-stores queue the register they will free, in program order.
  task automatic setAlloc1(input logic [5:0] preg, input logic [6:0] opc, input logic [5:0] old);
    rob_valid_1 = 1'b1; rob_p_reg_1 = preg; rob_opcode_1 = opc; o_rob_p_reg_1 = old;
    if (opc != OPC_STORE) freeQ.push_back(old);
    pendingAlloc++;
  endtask

  task automatic setAlloc2(input logic [5:0] preg, input logic [6:0] opc, input logic [5:0] old);
    rob_valid_2 = 1'b1; rob_p_reg_2 = preg; rob_opcode_2 = opc; o_rob_p_reg_2 = old;
    if (opc != OPC_STORE) freeQ.push_back(old);
    pendingAlloc++;
  endtask

  task automatic setBus(input int k, input logic [31:0] data, input logic [5:0] dest, input logic [3:0] idx);
    en_flag_ci = 1'b1;
    case (k)
      1: begin result_valid_c1 = 1'b1; result_c1 = data; result_dest_c1 = dest; result_ROB_c1 = idx; end
      2: begin result_valid_c2 = 1'b1; result_c2 = data; result_dest_c2 = dest; result_ROB_c2 = idx; end
      default: begin result_valid_c3 = 1'b1; result_c3 = data; result_dest_c3 = dest; result_ROB_c3 = idx; end
    endcase
  endtask

  task automatic checkRetire(input string tag, input logic [5:0] observed);
    if (freeQ.size() == 0) checkOutput({tag, "_queue"}, 32'(freeQ.size()), 32'd1);
    else checkOutput(tag, 32'(observed), 32'(freeQ.pop_front()));
  endtask

  task automatic applyStimulus();
    fwd_t e;
    logic enExp;
    e = '0;
    if (!rst && en_flag_ci) begin
      if (result_valid_c1) begin e.flag[0] = 1'b1; e.d1 = result_dest_c1; e.x1 = result_c1; end
      if (result_valid_c2) begin e.flag[1] = 1'b1; e.d2 = result_dest_c2; e.x2 = result_c2; end
      if (result_valid_c3) begin e.flag[2] = 1'b1; e.d3 = result_dest_c3; e.x3 = result_c3; end
    end
    fwdQ.push_back(e);
    enExp = rst ? 1'b0 : en_flag_ci;
    tailExp = rst ? 0 : (tailExp + pendingAlloc) % 16;
    pendingAlloc = 0;
    @(posedge clk);
    #1;
    e = fwdQ.pop_front();
    checkOutput("fwd_flags", 32'({forward_flag_3, forward_flag_2, forward_flag_1}), 32'(e.flag));
    checkOutput("dest_R_1", 32'(dest_R_1), 32'(e.d1));
    checkOutput("dest_R_2", 32'(dest_R_2), 32'(e.d2));
    checkOutput("dest_R_3", 32'(dest_R_3), 32'(e.d3));
    checkOutput("fwd_data_1", forwarded_data_1, e.x1);
    checkOutput("fwd_data_2", forwarded_data_2, e.x2);
    checkOutput("fwd_data_3", forwarded_data_3, e.x3);
    checkOutput("en_flag_co", 32'(en_flag_co), 32'(enExp));
    checkOutput("rob_tail", 32'(rob_tail), 32'(tailExp));
    if (retire_flag_1 === 1'b1) checkRetire("fp_ind_1", fp_ind_1);
    if (retire_flag_2 === 1'b1) checkRetire("fp_ind_2", fp_ind_2);
    clearInputs();
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    freeQ.delete();
  endtask

  function automatic logic [31:0] retPair();
    return 32'({retire_flag_2, retire_flag_1});
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();

    // Reset state
    doReset();
    checkOutput("reset_full", 32'(rob_full), 32'd0);
    checkOutput("reset_retire", retPair(), 32'd0);
    checkOutput("reset_fp", 32'({fp_ind_2, fp_ind_1}), 32'd0);
    applyStimulus();

    // Two allocations; younger completes first, both retire together once the older does
    setAlloc1(6'd33, OPC_ADD, 6'd5);
    setAlloc2(6'd34, OPC_ADD, 6'd6);
    applyStimulus();
    setBus(1, 32'd7, 6'd34, 4'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("t2_no_retire_a", retPair(), 32'd0);
    setBus(2, 32'd9, 6'd33, 4'd0);
    applyStimulus();
    checkOutput("t2_no_retire_b", retPair(), 32'd0);
    applyStimulus();
    checkOutput("t2_dual_retire", retPair(), 32'd3);
    applyStimulus();
    checkOutput("t2_quiet", retPair(), 32'd0);
    checkOutput("t2_freeq_empty", 32'(freeQ.size()), 32'd0);

    // Three buses at once, then buses gated off by en_flag_ci
    setBus(1, 32'd1, 6'd10, 4'd0);
    setBus(2, 32'd2, 6'd11, 4'd1);
    setBus(3, 32'd3, 6'd12, 4'd2);
    applyStimulus();
    setBus(3, 32'hDEAD_BEEF, 6'd63, 4'd5);
    en_flag_ci = 1'b0;
    applyStimulus();

    // Fill to 15 entries, drop further requests, then drain one and allocate across the wrap
    doReset();
    for (int i = 0; i < 7; i++) begin
      setAlloc1(6'(2 * i), OPC_ADD, 6'(2 * i));
      setAlloc2(6'(2 * i + 1), OPC_ADD, 6'(2 * i + 1));
      applyStimulus();
    end
    checkOutput("t4_not_full_14", 32'(rob_full), 32'd0);
    setAlloc1(6'd14, OPC_ADD, 6'd14);
    applyStimulus();
    checkOutput("t4_full_15", 32'(rob_full), 32'd1);
    rob_valid_1 = 1'b1; rob_p_reg_1 = 6'd50; rob_opcode_1 = OPC_ADD; o_rob_p_reg_1 = 6'd51;
    rob_valid_2 = 1'b1; rob_p_reg_2 = 6'd52; rob_opcode_2 = OPC_ADD; o_rob_p_reg_2 = 6'd53;
    applyStimulus();
    checkOutput("t4_still_full", 32'(rob_full), 32'd1);
    setBus(1, 32'h55, 6'd0, 4'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("t4_retire_head", 32'(retire_flag_1), 32'd1);
    checkOutput("t4_full_cleared", 32'(rob_full), 32'd0);
    setAlloc1(6'd60, OPC_ADD, 6'd61);
    applyStimulus();
    checkOutput("t4_wrap_tail", 32'(rob_tail), 32'd0);

    // Store at head retires silently and lets the next entry retire in slot 1
    doReset();
    setAlloc1(6'd40, OPC_STORE, 6'd20);
    setAlloc2(6'd41, OPC_ADD, 6'd21);
    applyStimulus();
    setBus(3, 32'd100, 6'd40, 4'd0);
    applyStimulus();
    applyStimulus();
    checkOutput("t5_store_silent", retPair(), 32'd0);
    setBus(1, 32'd101, 6'd41, 4'd1);
    applyStimulus();
    applyStimulus();
    checkOutput("t5_next_retires", retPair(), 32'd1);
    checkOutput("t5_freeq_empty", 32'(freeQ.size()), 32'd0);

    // 18 allocations with steady retirement across the 15->0 wrap
    doReset();
    for (int i = 0; i < 18; i++) begin
      setAlloc1(6'(i + 20), OPC_ADD, 6'(i + 30));
      if (i > 0) setBus(2, 32'(i), 6'(i + 19), 4'((i - 1) % 16));
      applyStimulus();
      if (i == 15) checkOutput("t6_tail_wrap", 32'(rob_tail), 32'd0);
    end
    setBus(2, 32'd18, 6'd37, 4'd1);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("t6_all_retired", 32'(freeQ.size()), 32'd0);

    // Reset while two completed entries wait to retire
    doReset();
    setAlloc1(6'd44, OPC_ADD, 6'd12);
    setAlloc2(6'd45, OPC_ADD, 6'd13);
    applyStimulus();
    setBus(1, 32'd5, 6'd44, 4'd0);
    setBus(2, 32'd6, 6'd45, 4'd1);
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput("t7_reset_no_retire", retPair(), 32'd0);
    freeQ.delete();
    applyStimulus();
    checkOutput("t7_after_reset", retPair(), 32'd0);
    checkOutput("t7_full", 32'(rob_full), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
